pc_unit_ras: RTL and testbench

//   Parametrised program-counter unit: next generation of the sequential PC.

---
 rtl/pc_unit_ras.sv | 116 +++++++++++
 tb/tb_pc_unit_ras.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: front-end program counter with stall, PC-relative redirects
// (branch/jump/call) and a circular return-address stack for call/return.
// Redirect priority: stall > ret > call > jump > branch > sequential.
module pc_unit_ras #(
  parameter int              WIDTH     = 32,
  parameter int              INC       = 4,
  parameter int              OFF_W     = 8,
  parameter int              OFF_SHIFT = 2,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int             SP_W      = $clog2(DEPTH),
  localparam int             CNT_W     = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch,
  input  logic             i_jump,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic [OFF_W-1:0] i_offset,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_seq,
  output logic [CNT_W-1:0] o_ras_count,
  output logic             o_ras_err
);

  logic [WIDTH-1:0]        r_pc;
  logic [SP_W-1:0]         r_sp;      // next slot to write; top is r_sp-1
  logic [CNT_W-1:0]        r_count;
  logic                    r_err;
  logic [WIDTH-1:0]        r_stack [DEPTH];

  logic [WIDTH-1:0]        w_pc_seq;
  logic signed [WIDTH-1:0] w_off_ext;
  logic [WIDTH-1:0]        w_tgt;
  logic [SP_W-1:0]         w_sp_dec;
  logic [WIDTH-1:0]        w_top;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_do_ret;
  logic                    w_do_call;
  logic                    w_do_push;

  logic [WIDTH-1:0]        w_pc_nxt;
  logic [SP_W-1:0]         w_sp_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    w_err_nxt;

  // Sequential and relative target addresses; all sums wrap modulo 2^WIDTH.
  assign w_pc_seq  = r_pc + WIDTH'(INC);
  assign w_off_ext = WIDTH'($signed(i_offset));
  assign w_tgt     = w_pc_seq + WIDTH'(w_off_ext <<< OFF_SHIFT);

  assign w_sp_dec  = r_sp - SP_W'(1);
  assign w_top     = r_stack[w_sp_dec];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));

  // Lower-priority requests are masked off entirely by higher ones.
  assign w_do_ret  = !i_stall && i_ret;
  assign w_do_call = !i_stall && !i_ret && i_call;
  assign w_do_push = !i_reset && w_do_call;

  // Next-state selection for PC and RAS bookkeeping.
  always_comb begin
    w_pc_nxt    = w_pc_seq;
    w_sp_nxt    = r_sp;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    if (i_stall) begin
      w_pc_nxt = r_pc;
    end else if (w_do_ret) begin
      if (w_empty) begin
        w_err_nxt = 1'b1;               // underflow: fall through sequentially
      end else begin
        w_pc_nxt    = w_top;
        w_sp_nxt    = w_sp_dec;
        w_count_nxt = r_count - CNT_W'(1);
      end
    end else if (w_do_call) begin
      w_pc_nxt = w_tgt;
      w_sp_nxt = r_sp + SP_W'(1);       // oldest slot is overwritten when full
      if (w_full) w_err_nxt   = 1'b1;
      else        w_count_nxt = r_count + CNT_W'(1);
    end else if (i_jump || i_branch) begin
      w_pc_nxt = w_tgt;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc    <= RESET_VEC;
      r_sp    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Return-address storage; contents need no reset, count tracks validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_stack[r_sp] <= w_pc_seq;
  end

  assign o_pc        = r_pc;
  assign o_pc_seq    = w_pc_seq;
  assign o_ras_count = r_count;
  assign o_ras_err   = r_err;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios plus randomized run against a
// queue-based reference model. A second 8-bit instance checks wraparound.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst, stall, branch, jump, call, ret;
  logic [7:0]  off;
  logic [31:0] pc, pc_seq;
  logic [2:0]  cnt;
  logic        err;
  logic [7:0]  pc8, pc_seq8;
  logic [2:0]  cnt8;
  logic        err8;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_err;

  always #5 clk = ~clk;

  pc_unit_ras dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_branch(branch),
    .i_jump(jump), .i_call(call), .i_ret(ret), .i_offset(off),
    .o_pc(pc), .o_pc_seq(pc_seq), .o_ras_count(cnt), .o_ras_err(err)
  );

  pc_unit_ras #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_branch(branch),
    .i_jump(jump), .i_call(call), .i_ret(ret), .i_offset(off),
    .o_pc(pc8), .o_pc_seq(pc_seq8), .o_ras_count(cnt8), .o_ras_err(err8)
  );

  // Drive one cycle of inputs, advance the model from the rules, then wait
  // for the edge and settle just after it.
  task automatic step(input logic r, input logic s, input logic b, input logic j,
                      input logic c, input logic t, input logic [7:0] o);
    logic [31:0] seq, tgt;
    rst = r; stall = s; branch = b; jump = j; call = c; ret = t; off = o;
    seq = m_pc + 32'd4;
    tgt = seq + ({{24{o[7]}}, o} * 32'd4);
    if (r) begin
      m_pc = 32'd0; m_q.delete(); m_err = 1'b0;
    end else if (s) begin
      // hold everything
    end else if (t) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = seq; m_err = 1'b1; end
    end else if (c) begin
      m_q.push_back(seq);
      if (m_q.size() > 4) begin void'(m_q.pop_front()); m_err = 1'b1; end
      m_pc = tgt;
    end else if (j || b) begin
      m_pc = tgt;
    end else begin
      m_pc = seq;
    end
    @(posedge clk); #1;
    rst = 0; stall = 0; branch = 0; jump = 0; call = 0; ret = 0; off = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12};
    for (int i = 0; i < 5; i++) begin
      step(i < 2, 0, 0, 0, 0, 0, 8'd0);
      if (i == 0) begin
        n_total++;
        if (pc !== 32'd0) $display("FAIL reset_pc0 got %0d want 0", pc); else n_pass++;
      end
    end
    n_total++;
    if (pc !== exp_pc[4]) $display("FAIL reset_run got %0d want %0d", pc, exp_pc[4]); else n_pass++;
    n_total++;
    if (cnt !== 3'd0 || err !== 1'b0)
      $display("FAIL reset_ras cnt=%0d err=%0b want 0/0", cnt, err); else n_pass++;
    n_total++;
    if (pc_seq !== 32'd16) $display("FAIL reset_pcseq got %0d want 16", pc_seq); else n_pass++;
  endtask

  task automatic test_branch();
    step(1, 0, 0, 0, 0, 0, 8'd0);
    run(2);
    step(0, 0, 1, 0, 0, 0, 8'hFD);
    n_total++;
    if (pc !== 32'd0) $display("FAIL branch_neg got %0d want 0", pc); else n_pass++;
    run(2);
    step(0, 0, 1, 0, 0, 0, 8'h7F);
    n_total++;
    if (pc !== 32'd520) $display("FAIL branch_max got %0d want 520", pc); else n_pass++;
    step(0, 0, 0, 1, 0, 0, 8'h80);
    n_total++;
    if (pc !== 32'd12) $display("FAIL jump_min got %0d want 12", pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    step(1, 0, 0, 0, 0, 0, 8'd0);
    run(4);
    step(0, 0, 0, 0, 1, 0, 8'd10);
    n_total++;
    if (pc !== 32'd60 || cnt !== 3'd1)
      $display("FAIL call pc=%0d cnt=%0d want 60/1", pc, cnt); else n_pass++;
    step(0, 0, 0, 0, 0, 1, 8'd0);
    n_total++;
    if (pc !== 32'd20 || cnt !== 3'd0)
      $display("FAIL ret pc=%0d cnt=%0d want 20/0", pc, cnt); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'd20, 32'd16, 32'd12, 32'd8};
    step(1, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 8'd0);
    n_total++;
    if (cnt !== 3'd4 || err !== 1'b1 || pc !== 32'd20)
      $display("FAIL overflow cnt=%0d err=%0b pc=%0d want 4/1/20", cnt, err, pc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 8'd0);
      n_total++;
      if (pc !== exp_ret[i]) $display("FAIL lifo_%0d got %0d want %0d", i, pc, exp_ret[i]); else n_pass++;
    end
    step(0, 0, 0, 0, 0, 1, 8'd0);
    n_total++;
    if (pc !== 32'd12 || cnt !== 3'd0 || err !== 1'b1)
      $display("FAIL underflow pc=%0d cnt=%0d err=%0b want 12/0/1", pc, cnt, err); else n_pass++;
  endtask

  task automatic test_stall_reset();
    step(1, 0, 0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 0, 1, 8'd0);
    step(0, 0, 0, 0, 1, 0, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 8'd5);
    n_total++;
    if (pc !== 32'd8 || cnt !== 3'd1 || err !== 1'b1)
      $display("FAIL stall pc=%0d cnt=%0d err=%0b want 8/1/1", pc, cnt, err); else n_pass++;
    step(1, 1, 0, 0, 1, 0, 8'd5);
    n_total++;
    if (pc !== 32'd0 || cnt !== 3'd0 || err !== 1'b0)
      $display("FAIL stall_reset pc=%0d cnt=%0d err=%0b want 0/0/0", pc, cnt, err); else n_pass++;
  endtask

  task automatic test_wrap_callret();
    step(1, 0, 0, 0, 0, 0, 8'd0);
    run(63);
    n_total++;
    if (pc8 !== 8'hFC) $display("FAIL wrap_pre got %0h want fc", pc8); else n_pass++;
    run(1);
    n_total++;
    if (pc8 !== 8'h00) $display("FAIL wrap got %0h want 0", pc8); else n_pass++;
    step(0, 0, 0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 0, 1, 1, 8'd7);
    n_total++;
    if (pc !== 32'd260 || cnt !== 3'd0 || err !== 1'b0)
      $display("FAIL call_ret pc=%0d cnt=%0d err=%0b want 260/0/0", pc, cnt, err); else n_pass++;
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           8'($urandom));
      n_total++;
      if (pc !== m_pc || pc_seq !== m_pc + 32'd4 || cnt !== 3'(m_q.size()) ||
          err !== m_err || pc8 !== m_pc[7:0]) begin
        $display("FAIL rand_%0d pc=%0h seq=%0h cnt=%0d err=%0b pc8=%0h want %0h/%0h/%0d/%0b/%0h",
                 i, pc, pc_seq, cnt, err, pc8, m_pc, m_pc + 32'd4, m_q.size(), m_err, m_pc[7:0]);
      end else n_pass++;
    end
  endtask

  initial begin
    rst = 1; stall = 0; branch = 0; jump = 0; call = 0; ret = 0; off = 0;
    m_pc = 0; m_err = 0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall_reset();
    test_wrap_callret();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
